aoi_sweep_checker: RTL and testbench

//  Synthesizable exhaustive stimulus generator and self-checker for N-pair AND-OR-INVERT cells.

---
 rtl/aoi_pkg.sv | 32 +++
 rtl/aoi_vec_gen.sv | 60 ++++++
 rtl/aoi_sweep_checker.sv | 144 ++++++++++++++
 tb/tb_aoi_sweep_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// rtl/aoi_pkg.sv - shared types and helpers for the AOI sweep checker
// Purpose: FSM state type, golden AND-OR-INVERT model and binary-to-Gray encoder.
// Ports: none (package).
package aoi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest vector the helpers accept: 8 pairs -> 16 bits, plus one index guard bit.
  localparam int MAX_W = 16;

  // Golden AOI: output is low when any pair has both of its inputs high.
  // Pair k lives in bits [2k+1:2k]; pairs at or above n_pairs are ignored.
  function automatic logic aoi_golden(input logic [MAX_W-1:0] vec, input int n_pairs);
    logic any_and;
    any_and = 1'b0;
    for (int k = 0; k < MAX_W / 2; k++) begin
      if (k < n_pairs) begin
        any_and = any_and | (vec[2*k] & vec[2*k+1]);
      end
    end
    return ~any_and;
  endfunction

  function automatic logic [MAX_W:0] bin2gray(input logic [MAX_W:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/aoi_vec_gen.sv
// rtl/aoi_vec_gen.sv - sweep index counter with binary/Gray vector encoder
// Purpose: holds the sweep index and the registered vector driven to the cell.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           force index and vector to zero (abort)
//   load            restart sweep at index 0 and latch gray_mode
//   advance         step to the next index and register its encoding
//   gray_mode       0: binary order, 1: Gray order (sampled on load)
//   idx             current index, W+1 bits
//   vec             registered vector for the cell under test
module aoi_vec_gen
  import aoi_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         advance,
  input  logic         gray_mode,
  output logic [W:0]   idx,
  output logic [W-1:0] vec
);

  logic         mode;
  logic [W:0]   idx_next;
  logic [W-1:0] enc_next;

  assign idx_next = idx + (W+1)'(1);

  // Encode the next index so the vector changes on the same edge as the index.
  always_comb begin
    enc_next = idx_next[W-1:0];
    if (mode) begin
      enc_next = W'(bin2gray((MAX_W+1)'(idx_next)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      vec  <= '0;
      mode <= 1'b0;
    end else if (clear) begin
      idx  <= '0;
      vec  <= '0;
      mode <= 1'b0;
    end else if (load) begin
      // Index 0 encodes to 0 in both orders.
      idx  <= '0;
      vec  <= '0;
      mode <= gray_mode;
    end else if (advance) begin
      idx <= idx_next;
      vec <= enc_next;
    end
  end

endmodule

// File: rtl/aoi_sweep_checker.sv
// rtl/aoi_sweep_checker.sv - exhaustive sweep generator and checker for N-pair AOI cells
// Purpose: walks every input vector of an AOI cell, holds each for HOLD_CYCLES,
//   compares the cell response with the golden AOI and reports the result.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            begin a sweep (IDLE or DONE only)
//   abort            stop and clear, return to IDLE (wins over start)
//   gray_mode        vector order, sampled on accepted start
//   dut_in           vector driven to the cell, {pair N-1 ... pair 0}
//   dut_out          cell response
//   busy, done, pass sweep status
//   err_count        saturating mismatch count
//   first_err_valid  a mismatch has been captured this sweep
//   first_err_vec    vector of the first mismatch
module aoi_sweep_checker
  import aoi_pkg::*;
#(
  parameter int N_PAIRS     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 gray_mode,
  output logic [2*N_PAIRS-1:0] dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [2*N_PAIRS-1:0] first_err_vec
);

  localparam int W      = 2 * N_PAIRS;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [W:0]        IDX_LAST  = {1'b0, {W{1'b1}}};

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold;
  logic [W:0]        idx;
  logic              at_compare;
  logic              accept_start;
  logic              advance;
  logic              expected;
  logic              mismatch;

  aoi_vec_gen #(
    .W(W)
  ) u_vec_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .load      (accept_start),
    .advance   (advance),
    .gray_mode (gray_mode),
    .idx       (idx),
    .vec       (dut_in)
  );

  assign expected = aoi_golden(MAX_W'(dut_in), N_PAIRS);
  assign mismatch = at_compare && (dut_out != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    at_compare   = 1'b0;
    accept_start = 1'b0;
    advance      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next   = DRIVE;
            accept_start = 1'b1;
          end
        end
        DRIVE: begin
          busy       = 1'b1;
          at_compare = (hold == HOLD_LAST);
          if (at_compare) begin
            // The index has one guard bit, so the terminal test never wraps.
            if (idx == IDX_LAST) begin
              state_next = DONE;
            end else begin
              advance = 1'b1;
            end
          end
        end
        DONE: begin
          done = 1'b1;
          if (start) begin
            state_next   = DRIVE;
            accept_start = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold            <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (abort || accept_start) begin
      hold            <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (state == DRIVE) begin
      hold <= at_compare ? '0 : hold + HOLD_W'(1);
      if (mismatch) begin
        if (err_count != '1) begin
          err_count <= err_count + ERR_W'(1);
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= dut_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_aoi_sweep_checker.sv
// tb/tb_aoi_sweep_checker.sv - directed bench for aoi_sweep_checker
module tb_aoi_sweep_checker;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic gray_mode;

  logic [3:0] m_in;
  logic       m_out;
  logic       m_busy, m_done, m_pass, m_fev;
  logic [7:0] m_err;
  logic [3:0] m_fvec;
  int         m_mode;

  logic [3:0] s_in;
  logic       s_out;
  logic       s_busy, s_done, s_pass, s_fev;
  logic [1:0] s_err;
  logic [3:0] s_fvec;

  logic [5:0] w_in;
  logic       w_out;
  logic       w_busy, w_done, w_pass, w_fev;
  logic [7:0] w_err;
  logic [5:0] w_fvec;

  int total;
  int bad;

  aoi_sweep_checker #(.N_PAIRS(2), .HOLD_CYCLES(4), .ERR_W(8)) u_main (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gray_mode(gray_mode),
    .dut_in(m_in), .dut_out(m_out), .busy(m_busy), .done(m_done), .pass(m_pass),
    .err_count(m_err), .first_err_valid(m_fev), .first_err_vec(m_fvec)
  );

  aoi_sweep_checker #(.N_PAIRS(2), .HOLD_CYCLES(4), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gray_mode(gray_mode),
    .dut_in(s_in), .dut_out(s_out), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_err_valid(s_fev), .first_err_vec(s_fvec)
  );

  aoi_sweep_checker #(.N_PAIRS(3), .HOLD_CYCLES(1), .ERR_W(8)) u_wide (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gray_mode(gray_mode),
    .dut_in(w_in), .dut_out(w_out), .busy(w_busy), .done(w_done), .pass(w_pass),
    .err_count(w_err), .first_err_valid(w_fev), .first_err_vec(w_fvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell models: main is golden / stuck-1 / stuck-0, sat is stuck-0, wide is golden.
  always_comb begin
    case (m_mode)
      1:       m_out = 1'b1;
      2:       m_out = 1'b0;
      default: m_out = ~((m_in[3] & m_in[2]) | (m_in[1] & m_in[0]));
    endcase
  end
  assign s_out = 1'b0;
  assign w_out = ~((w_in[5] & w_in[4]) | (w_in[3] & w_in[2]) | (w_in[1] & w_in[0]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [5:0] prev_w;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    gray_mode = 1'b0;
    m_mode    = 0;
    tick(3);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_pass", 32'(m_pass), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    check("rst_fev", 32'(m_fev), 32'd0);
    check("rst_fvec", 32'(m_fvec), 32'd0);
    check("rst_din", 32'(m_in), 32'd0);
    rst = 1'b0;

    // 1: golden cell, binary order, exact 64-cycle latency
    pulse_start();
    tick(63);
    check("t1_busy_63", 32'(m_busy), 32'd1);
    check("t1_done_63", 32'(m_done), 32'd0);
    check("t1_wdone_63", 32'(w_done), 32'd0);
    tick(1);
    check("t1_done", 32'(m_done), 32'd1);
    check("t1_busy", 32'(m_busy), 32'd0);
    check("t1_pass", 32'(m_pass), 32'd1);
    check("t1_err", 32'(m_err), 32'd0);
    check("t1_fev", 32'(m_fev), 32'd0);
    check("t1_hold_last", 32'(m_in), 32'hF);
    check("t3_sat_err", 32'(s_err), 32'd3);
    check("t3_sat_fvec", 32'(s_fvec), 32'd0);
    check("t3_sat_pass", 32'(s_pass), 32'd0);
    check("t6_wide_done", 32'(w_done), 32'd1);
    check("t6_wide_pass", 32'(w_pass), 32'd1);

    // 2: stuck-1, binary then Gray (restart from DONE clears counts)
    m_mode = 1;
    pulse_start();
    tick(64);
    check("t2b_done", 32'(m_done), 32'd1);
    check("t2b_err", 32'(m_err), 32'd7);
    check("t2b_fvec", 32'(m_fvec), 32'h3);
    check("t2b_pass", 32'(m_pass), 32'd0);

    gray_mode = 1'b1;
    pulse_start();
    gray_mode = 1'b0;
    prev_w = w_in;
    check("t6_gray_first", 32'(w_in), 32'd0);
    for (int k = 1; k < 64; k++) begin
      tick(1);
      check("t6_gray_step", 32'($countones(prev_w ^ w_in)), 32'd1);
      prev_w = w_in;
    end
    tick(1);
    check("t6_gray_pass", 32'(w_pass), 32'd1);
    check("t2g_done", 32'(m_done), 32'd1);
    check("t2g_err", 32'(m_err), 32'd7);
    check("t2g_fvec", 32'(m_fvec), 32'h3);
    check("t2g_hold_last", 32'(m_in), 32'h8);

    // 3: stuck-0
    m_mode = 2;
    pulse_start();
    tick(64);
    check("t3_err", 32'(m_err), 32'd9);
    check("t3_fev", 32'(m_fev), 32'd1);
    check("t3_fvec", 32'(m_fvec), 32'h0);
    check("t3_pass", 32'(m_pass), 32'd0);

    // 4: start while busy ignored, abort (with start) at cycle 20
    m_mode = 1;
    pulse_start();
    tick(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("t4_ignore_start", 32'(m_in), 32'h3);
    check("t4_busy", 32'(m_busy), 32'd1);
    tick(7);
    check("t4_err_pre", 32'(m_err), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    check("t4_busy_ab", 32'(m_busy), 32'd0);
    check("t4_done_ab", 32'(m_done), 32'd0);
    check("t4_err_ab", 32'(m_err), 32'd0);
    check("t4_fev_ab", 32'(m_fev), 32'd0);
    check("t4_din_ab", 32'(m_in), 32'd0);
    tick(2);
    check("t4_idle_stays", 32'(m_busy), 32'd0);

    // 5: asynchronous reset mid-sweep, then a full clean sweep
    pulse_start();
    tick(30);
    check("t5_err_pre", 32'(m_err), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(m_busy), 32'd0);
    check("t5_err", 32'(m_err), 32'd0);
    check("t5_fev", 32'(m_fev), 32'd0);
    check("t5_din", 32'(m_in), 32'd0);
    check("t5_wbusy", 32'(w_busy), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_mode = 0;
    pulse_start();
    tick(63);
    check("t5_done_63", 32'(m_done), 32'd0);
    tick(1);
    check("t5_done", 32'(m_done), 32'd1);
    check("t5_pass", 32'(m_pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
